// File: rtl/wb_select_reg_pkg.sv
// wb_select_reg_pkg: shared write-back state encoding, register address width and source channel indices
package wb_select_reg_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} wb_state_t;
  localparam int REG_ADDR_W  = 5;
  localparam int WB_ULA      = 0;
  localparam int WB_SIGNEXT1 = 1;
  localparam int WB_SHIFT    = 2;
  localparam int WB_HI       = 3;
  localparam int WB_LO       = 4;
  localparam int WB_LUI      = 5;
  localparam int WB_LOAD     = 6;
endpackage

// File: rtl/wb_wait_timer.sv
// wb_wait_timer: clearable wait counter that flags the last allowed cycle (LIMIT=0 never expires)
module wb_wait_timer #(
  parameter int CNT_W = 5,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + 1'b1;
  assign expired = (LIMIT != 0) && (count == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/wb_select_reg.sv
// wb_select_reg: registered write-back source select that waits (with timeout) for the chosen source to become valid
module wb_select_reg
  import wb_select_reg_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int N             = 8,
  parameter int SEL_W         = 3,
  parameter int TIMEOUT       = 16,
  parameter int CNT_W         = 5,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic [N*WIDTH-1:0]    src_data,
  input  logic [N-1:0]          src_valid,
  output logic                  busy,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]      wb_data,
  output logic                  err_sel,
  output logic                  err_timeout
);
  wb_state_t             state;
  logic [SEL_W-1:0]      sel_q, idx;
  logic [REG_ADDR_W-1:0] dest_q, cdest;
  logic [WIDTH-1:0]      ch [N];
  logic                  illegal, hit, commit, keep, expired;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = src_data[i*WIDTH +: WIDTH];
  end
  // In WAIT the latched request drives the mux; in IDLE the live inputs do.
  assign idx     = (state == WAIT) ? sel_q : sel;
  assign cdest   = (state == WAIT) ? dest_q : dest;
  assign illegal = 32'(sel) >= N;
  assign hit     = src_valid[idx];
  assign commit  = hit && ((state == WAIT) || (start && !illegal));
  assign keep    = !((ZERO_SUPPRESS != 0) && (cdest == '0));
  assign busy    = (state == WAIT);
  wb_wait_timer #(.CNT_W(CNT_W), .LIMIT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .en     (state == WAIT),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= '0;
      dest_q      <= '0;
      wb_we       <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wb_we       <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
      if (state == IDLE) begin
        if (start && illegal) err_sel <= 1'b1;
        else if (start && !hit) begin
          sel_q  <= sel;
          dest_q <= dest;
          state  <= WAIT;
        end
      end else if (hit) state <= IDLE;
      else if (expired) begin
        err_timeout <= 1'b1;
        state       <= IDLE;
      end
      if (commit && keep) begin
        wb_we   <= 1'b1;
        wb_addr <= cdest;
        wb_data <= ch[idx];
      end
    end
  end
endmodule

// File: tb/tb_wb_select_reg.sv
// tb_wb_select_reg: directed and random stimulus against a transaction-level write-back model
module tb_wb_select_reg;
  localparam int WIDTH = 32, N = 7, SEL_W = 3, TIMEOUT = 16, CNT_W = 5, ZS = 1;
  logic clk = 1'b0, reset, start, busy, wb_we, err_sel, err_timeout;
  logic [SEL_W-1:0] sel;
  logic [4:0] dest, wb_addr;
  logic [N*WIDTH-1:0] src_data;
  logic [N-1:0] src_valid;
  logic [WIDTH-1:0] wb_data;
  int n_tests = 0, n_fail = 0;
  bit m_wait, e_we, e_esel, e_eto;
  int m_sel, m_dest, m_age;
  logic [4:0] e_addr;
  logic [WIDTH-1:0] e_data;
  wb_select_reg #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
                  .ZERO_SUPPRESS(ZS)) dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .dest(dest), .src_data(src_data),
    .src_valid(src_valid), .busy(busy), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .err_sel(err_sel), .err_timeout(err_timeout));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [WIDTH-1:0] chan(int c);
    return WIDTH'(src_data >> (c * WIDTH));
  endfunction
  function automatic bit vld(int c);
    return ((src_valid >> c) & 1) != 0;
  endfunction
  task automatic set_ch(int c, logic [WIDTH-1:0] v);
    src_data = (src_data & ~((N*WIDTH)'({WIDTH{1'b1}}) << (c * WIDTH))) | ((N*WIDTH)'(v) << (c * WIDTH));
  endtask
  task automatic clear_model();
    m_wait = 0; e_we = 0; e_esel = 0; e_eto = 0; e_addr = '0; e_data = '0; m_age = 0;
  endtask
  task automatic model_commit(int c, int d);
    if (!(ZS != 0 && d == 0)) begin
      e_we = 1; e_addr = 5'(d); e_data = chan(c);
    end
  endtask
  // One clock edge of the transaction model: a request either commits, errors, or waits its turn.
  task automatic model_edge();
    e_we = 0; e_esel = 0; e_eto = 0;
    if (m_wait) begin
      if (vld(m_sel)) begin
        model_commit(m_sel, m_dest); m_wait = 0;
      end else begin
        m_age++;
        if (TIMEOUT != 0 && m_age == TIMEOUT) begin e_eto = 1; m_wait = 0; end
      end
    end else if (start) begin
      if (int'(sel) >= N) e_esel = 1;
      else if (vld(int'(sel))) model_commit(int'(sel), int'(dest));
      else begin m_wait = 1; m_sel = int'(sel); m_dest = int'(dest); m_age = 0; end
    end
  endtask
  task automatic compare_all();
    check("busy", 64'(busy), 64'(m_wait));
    check("wb_we", 64'(wb_we), 64'(e_we));
    check("wb_addr", 64'(wb_addr), 64'(e_addr));
    check("wb_data", 64'(wb_data), 64'(e_data));
    check("err_sel", 64'(err_sel), 64'(e_esel));
    check("err_timeout", 64'(err_timeout), 64'(e_eto));
  endtask
  task automatic step();
    model_edge();
    @(posedge clk);
    #1 compare_all();
  endtask
  task automatic rand_data();
    for (int i = 0; i < N; i++) set_ch(i, $urandom);
  endtask
  initial begin
    reset = 1; start = 0; sel = '0; dest = '0; src_data = '0; src_valid = '0;
    clear_model();
    #3 compare_all();
    @(posedge clk);
    #1 reset = 0;
    rand_data();
    src_valid = '1; set_ch(3, 32'hDEADBEEF);
    start = 1; sel = 3; dest = 9; step();
    start = 0; step();
    src_valid[4] = 0; set_ch(4, 32'h0000_1234);
    start = 1; sel = 4; dest = 2; step();
    start = 0; repeat (4) step();
    src_valid[4] = 1; step(); step();
    src_valid[3] = 0; start = 1; sel = 3; dest = 7; step();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5); sel = 1; dest = 8;
      step();
    end
    start = 0;
    start = 1; sel = 7; dest = 4; step();
    start = 0; step();
    start = 1; sel = 0; dest = 0; step();
    start = 0; step();
    src_valid[5] = 0; start = 1; sel = 5; dest = 12; step();
    start = 0; repeat (15) step();
    src_valid[5] = 1; step(); step();
    src_valid = '1; rand_data();
    start = 1; sel = 1; dest = 3; step();
    sel = 2; dest = 4; set_ch(1, 32'h1111_0000); step();
    sel = 6; dest = 31; step();
    start = 0; step();
    src_valid[2] = 0; start = 1; sel = 2; dest = 5; step();
    start = 0; repeat (3) step();
    #2 reset = 1;
    clear_model();
    #1 compare_all();
    @(posedge clk);
    #1 reset = 0;
    step();
    src_valid = '1; start = 1; sel = 2; dest = 6; step();
    start = 0; step();
    repeat (400) begin
      start = ($urandom_range(0, 2) == 0);
      sel = SEL_W'($urandom_range(0, 7));
      dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      src_valid = N'($urandom) & N'($urandom);
      rand_data();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
